score_bcd_display: RTL and testbench

Consumer end of the game score interface. Takes the 12-bit binary score from the event-clocked score counters, which are asynchronous to clk. It resynchronises and stability-filters the score, converts it to 4 BCD digits with an iterative double-dabble FSM, and drives four active-low 7-segment digits. It also keeps a session high score, selectable for display.

---
 rtl/score_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 30 +++
 rtl/score_bcd_display.sv | 133 +++++++++++++
 tb/tb_score_bcd_display.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared widths, FSM states and 7-segment patterns for the score display
package score_pkg;

  localparam int SCORE_W    = 12;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Active-low segments, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - one BCD digit to active-low 7-segment pattern with blanking
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins; codes 10-15 cannot come out of the converter and show dark
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// rtl/score_bcd_display.sv - resync, filter, double-dabble convert and display the game score
module score_bcd_display
  import score_pkg::*;
#(
  parameter int W        = SCORE_W,
  parameter int DIGITS   = BCD_DIGITS,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [W-1:0]      score,
  input  logic              show_high,
  input  logic              hs_clear,
  output logic [4*DIGITS-1:0] bcd,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic              busy,
  output logic [W-1:0]      high_score
);

  localparam int         BW       = 4 * DIGITS;
  localparam int         SH_W     = BW + W;
  localparam logic [3:0] LAST_CNT = 4'(W - 1);

  logic [W-1:0]    sync1, sync2, s_prev;
  logic            stable;
  logic [W-1:0]    src;
  logic [W-1:0]    last_val, conv_val;
  logic            last_sel;
  logic [SH_W-1:0] sh, sh_adj;
  logic [3:0]      cnt;
  state_t          state;
  logic [3:0]      lz_blank;

  // A value is trusted only once it has survived two consecutive samples,
  // so a one-cycle mix of old and new counter bits never gets through
  assign stable = (sync2 == s_prev);
  assign src    = show_high ? high_score : sync2;

  // Two-flop synchroniser plus one-cycle history for the stability filter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '0;
      sync2  <= '0;
      s_prev <= '0;
    end else begin
      sync1  <= score;
      sync2  <= sync1;
      s_prev <= sync2;
    end
  end

  // Session maximum of the filtered score; clear pulse overrides an update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      high_score <= '0;
    end else if (hs_clear) begin
      high_score <= '0;
    end else if (stable && (sync2 > high_score)) begin
      high_score <= sync2;
    end
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  always_comb begin
    sh_adj = sh;
    for (int k = 0; k < DIGITS; k++) begin
      if (sh[W + 4*k +: 4] >= 4'd5) begin
        sh_adj[W + 4*k +: 4] = sh[W + 4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: load on a new stable source, shift W times, then latch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      last_val <= '0;
      conv_val <= '0;
      last_sel <= 1'b0;
      busy     <= 1'b0;
      bcd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stable && ((src != last_val) || (show_high != last_sel))) begin
            sh       <= {{BW{1'b0}}, src};
            conv_val <= src;
            cnt      <= '0;
            last_sel <= show_high;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sh  <= {sh_adj[SH_W-2:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          bcd      <= sh[SH_W-1:W];
          last_val <= conv_val;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Leading-zero blanking walks down from the top digit; units always lit
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (BLANK_LZ != 0) && (bcd[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (bcd[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (bcd[7:4] == 4'd0);
  end

  seg7_decode u_seg0 (.digit(bcd[3:0]),   .blank(lz_blank[0]), .seg(hex0));
  seg7_decode u_seg1 (.digit(bcd[7:4]),   .blank(lz_blank[1]), .seg(hex1));
  seg7_decode u_seg2 (.digit(bcd[11:8]),  .blank(lz_blank[2]), .seg(hex2));
  seg7_decode u_seg3 (.digit(bcd[15:12]), .blank(lz_blank[3]), .seg(hex3));

endmodule

// File: tb/tb_score_bcd_display.sv
// tb/tb_score_bcd_display.sv - scoreboard bench for score_bcd_display
module tb_score_bcd_display;

  logic        clk;
  logic        resetn;
  logic [11:0] score;
  logic        show_high;
  logic        hs_clear;
  logic [15:0] bcd;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        busy;
  logic [11:0] high_score;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];
  logic        busy_d = 1'b0;

  score_bcd_display #(.W(12), .DIGITS(4), .BLANK_LZ(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .score      (score),
    .show_high  (show_high),
    .hs_clear   (hs_clear),
    .bcd        (bcd),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .busy       (busy),
    .high_score (high_score)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {hex3,hex2,hex1,hex0} with leading zeros blanked
  function automatic logic [27:0] exp_hex(input logic [15:0] v);
    logic [6:0] h3, h2, h1, h0;
    h3 = (v[15:12] == 0) ? 7'h7F : seg_of(v[15:12]);
    h2 = (v[15:8]  == 0) ? 7'h7F : seg_of(v[11:8]);
    h1 = (v[15:4]  == 0) ? 7'h7F : seg_of(v[7:4]);
    h0 = seg_of(v[3:0]);
    return {h3, h2, h1, h0};
  endfunction

  // Monitor: every busy falling edge is a latched result; pop and compare
  always @(negedge clk) begin
    if (resetn) begin
      if (busy_d && !busy) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_latch: got bcd %h, expected no conversion", bcd);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("latch_bcd", {16'h0, bcd}, {16'h0, e});
          check("latch_hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, exp_hex(e)});
        end
      end
    end
    busy_d = busy;
  end

  task automatic wait_idle();
    int quiet = 0;
    int t = 0;
    while (quiet < 8 && t < 300) begin
      @(negedge clk);
      t++;
      quiet = busy ? 0 : quiet + 1;
    end
    check("idle_timeout", {31'h0, (t < 300)}, 32'h1);
  endtask

  task automatic wait_busy(input logic level, input int limit, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < limit) begin
      @(negedge clk);
      t++;
      if (busy == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    resetn    = 1'b0;
    score     = 12'd0;
    show_high = 1'b0;
    hs_clear  = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // 1: reset state
    check("rst_bcd",  {16'h0, bcd}, 32'h0);
    check("rst_hex0", {25'h0, hex0}, {25'h0, 7'b1000000});
    check("rst_hex1", {25'h0, hex1}, {25'h0, 7'h7F});
    check("rst_hex2", {25'h0, hex2}, {25'h0, 7'h7F});
    check("rst_hex3", {25'h0, hex3}, {25'h0, 7'h7F});
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_high", {20'h0, high_score}, 32'h0);

    // 2: single-digit value with exact latency
    score = 12'd7;
    exp_q.push_back(16'h0007);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 3)  check("lat_busy_e3",  {31'h0, busy}, 32'h0);
      if (i == 4)  check("lat_busy_e4",  {31'h0, busy}, 32'h1);
      if (i == 16) check("lat_busy_e16", {31'h0, busy}, 32'h1);
      if (i == 17) begin
        check("lat_busy_e17", {31'h0, busy}, 32'h0);
        check("lat_bcd_e17",  {16'h0, bcd}, 32'h0007);
        check("lat_hex0_e17", {25'h0, hex0}, {25'h0, 7'b1111000});
        check("lat_hex3_e17", {25'h0, hex3}, {25'h0, 7'h7F});
      end
    end
    wait_idle();

    // 3: full-scale value
    score = 12'd4095;
    exp_q.push_back(16'h4095);
    wait_idle();
    check("max_hex3", {25'h0, hex3}, {25'h0, 7'b0011001});
    check("max_hex2", {25'h0, hex2}, {25'h0, 7'b1000000});
    check("max_hex1", {25'h0, hex1}, {25'h0, 7'b0010000});
    check("max_hex0", {25'h0, hex0}, {25'h0, 7'b0010010});
    check("max_high", {20'h0, high_score}, 32'd4095);

    // 4: change mid-conversion is held off, then converted back-to-back
    score = 12'd123;
    exp_q.push_back(16'h0123);
    wait_busy(1'b1, 20, ok);
    check("mid_start", {31'h0, ok}, 32'h1);
    repeat (5) @(negedge clk);
    score = 12'd124;
    exp_q.push_back(16'h0124);
    wait_busy(1'b0, 20, ok);
    check("mid_first_latch", {31'h0, ok}, 32'h1);
    check("mid_first_bcd", {16'h0, bcd}, 32'h0123);
    wait_busy(1'b1, 17, ok);
    if (ok) wait_busy(1'b0, 17, ok);
    check("mid_second_in_time", {31'h0, ok}, 32'h1);
    check("mid_second_bcd", {16'h0, bcd}, 32'h0124);
    wait_idle();

    // 5: one-cycle glitch is filtered; high score already 4095 so reset first
    resetn = 1'b0;
    score  = 12'h0FF;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back(16'h0255);
    wait_idle();
    score = 12'h1FF;
    @(negedge clk);
    score = 12'h100;
    exp_q.push_back(16'h0256);
    wait_idle();
    check("glitch_bcd",  {16'h0, bcd}, 32'h0256);
    check("glitch_high", {20'h0, high_score}, 32'd256);

    // 6: high score display and clear
    score = 12'd57;
    exp_q.push_back(16'h0057);
    wait_idle();
    score = 12'd0;
    exp_q.push_back(16'h0000);
    wait_idle();
    check("hs_keep", {20'h0, high_score}, 32'd256);
    show_high = 1'b1;
    exp_q.push_back(16'h0256);
    wait_idle();
    hs_clear = 1'b1;
    @(negedge clk);
    hs_clear = 1'b0;
    exp_q.push_back(16'h0000);
    wait_idle();
    check("hs_cleared", {20'h0, high_score}, 32'd0);
    check("hs_bcd", {16'h0, bcd}, 32'h0000);

    // 6b: after clear, 57 becomes the new maximum and is shown
    score = 12'd57;
    exp_q.push_back(16'h0057);
    wait_idle();
    check("hs_new_high", {20'h0, high_score}, 32'd57);
    score = 12'd0;
    wait_idle();
    check("hs_bcd_57", {16'h0, bcd}, 32'h0057);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
